// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - two-requester arbiter sharing one 32-bit compare unit; optional macro CMP_ARB_RR_EN selects round-robin
module cmp_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [2:0]  op0,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   output logic        gnt0,
   input  logic        req1,
   input  logic [2:0]  op1,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        gnt1,
   output logic        res_valid,
   output logic        res_id,
   output logic        res_true,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        last_id;
   logic        win_id;
   logic        cap_id;
   logic [2:0]  cap_op;
   logic [31:0] cap_a;
   logic [31:0] cap_b;
   logic        a_neg;
   logic        a_zero;
   logic        cmp_out;

   // next-state, arbitration and grant/strobe decode
   always_comb begin
      state_nxt = state;
      win_id    = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      res_valid = 1'b0;
      case (state)
         IDLE: begin
            if (!reset && (req0 || req1)) begin
               if (req0 && req1) begin
`ifdef CMP_ARB_RR_EN
                  win_id = ~last_id;
`else
                  // fixed priority: requester 0 wins; last_id is tracked but ignored
                  win_id = last_id & 1'b0;
`endif
               end else begin
                  win_id = ~req0;
               end
               gnt0      = ~win_id;
               gnt1      = win_id;
               state_nxt = EVAL;
            end
         end
         EVAL: state_nxt = DONE;
         DONE: begin
            res_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // shared comparator on the captured operands; b only matters for EQ/NE
   always_comb begin
      a_neg  = cap_a[31];
      a_zero = (cap_a == 32'd0);
      case (cap_op)
         3'b000:  cmp_out = (cap_a == cap_b);
         3'b001:  cmp_out = (cap_a != cap_b);
         3'b010:  cmp_out = a_neg | a_zero;
         3'b011:  cmp_out = ~a_neg & ~a_zero;
         3'b100:  cmp_out = a_neg;
         3'b101:  cmp_out = ~a_neg;
         default: cmp_out = 1'b0;
      endcase
   end

   // control state, arbitration pointer and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         last_id  <= 1'b1;
         res_id   <= 1'b0;
         res_true <= 1'b0;
      end else begin
         state <= state_nxt;
         if (gnt0 || gnt1) begin
            last_id <= gnt1;
         end
         if (state == EVAL) begin
            res_id   <= cap_id;
            res_true <= cmp_out;
         end
      end
   end

   // operand capture, only in the grant cycle
   always_ff @(posedge clk) begin
      if (gnt0 || gnt1) begin
         cap_id <= gnt1;
         cap_op <= gnt1 ? op1 : op0;
         cap_a  <= gnt1 ? a1 : a0;
         cap_b  <= gnt1 ? b1 : b0;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench for cmp_arbiter
module tb_cmp_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [2:0]  op0, op1;
   logic [31:0] a0, b0, a1, b1;
   logic        gnt0, gnt1, res_valid, res_id, res_true, busy;

   cmp_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
      .res_valid(res_valid), .res_id(res_id), .res_true(res_true), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state: time of last accepted grant and visible result
   int  t      = 0;
   int  g_t    = -1000;
   bit  m_last = 1'b1;
   bit  m_rid  = 1'b0;
   bit  m_rt   = 1'b0;
   bit  p_id   = 1'b0;
   bit  p_rt   = 1'b0;
   bit  armed  = 1'b0;

   bit s_g0, s_g1, s_busy, s_rv, s_rid, s_rt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
      end
   endtask

   function automatic bit ref_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa;
      sa = a;
      case (op)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd2: return sa <= 0;
         3'd3: return sa > 0;
         3'd4: return sa < 0;
         3'd5: return sa >= 0;
         default: return 1'b0;
      endcase
   endfunction

   // one clock cycle: drive, check against model, let the edge happen, advance model
   task automatic cyc(input bit r,
                      input bit q0, input logic [2:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                      input bit q1, input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1);
      int  d;
      bit  free, gv, w;
      @(negedge clk);
      reset = r; req0 = q0; op0 = o0; a0 = x0; b0 = y0;
      req1 = q1; op1 = o1; a1 = x1; b1 = y1;
      #1;
      s_g0 = gnt0; s_g1 = gnt1; s_busy = busy; s_rv = res_valid; s_rid = res_id; s_rt = res_true;
      d    = t - g_t;
      free = (d >= 3);
      gv   = !r && free && (q0 || q1);
`ifdef CMP_ARB_RR_EN
      w = (q0 && q1) ? !m_last : !q0;
`else
      w = (q0 && q1) ? 1'b0 : !q0;
`endif
      if (armed) begin
         chk("model gnt0", s_g0, gv && !w);
         chk("model gnt1", s_g1, gv && w);
         chk("model busy", s_busy, !free);
         chk("model res_valid", s_rv, d == 2);
         chk("model res_id", s_rid, m_rid);
         chk("model res_true", s_rt, m_rt);
      end
      @(posedge clk);
      if (r) begin
         g_t = -1000; m_last = 1'b1; m_rid = 1'b0; m_rt = 1'b0;
      end else begin
         if (d == 1) begin
            m_rid = p_id; m_rt = p_rt;
         end
         if (gv) begin
            g_t = t; m_last = w; p_id = w;
            p_rt = w ? ref_cmp(o1, x1, y1) : ref_cmp(o0, x0, y0);
         end
      end
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rst();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hffff_ffff;
         3: return 32'h7fff_ffff;
         4: return 32'h0000_0001;
         5: return 32'h0000_0005;
         default: return $urandom;
      endcase
   endfunction

   typedef struct {
      bit          id;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          exp;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{1, 3'd4, 32'h8000_0000, 32'h0,         1};
      tbl[1]  = '{1, 3'd5, 32'h8000_0000, 32'h0,         0};
      tbl[2]  = '{1, 3'd2, 32'h0000_0000, 32'h0,         1};
      tbl[3]  = '{0, 3'd5, 32'h0000_0000, 32'h1,         1};
      tbl[4]  = '{0, 3'd3, 32'h0000_0000, 32'h0,         0};
      tbl[5]  = '{1, 3'd4, 32'h0000_0000, 32'h0,         0};
      tbl[6]  = '{0, 3'd0, 32'h0000_0005, 32'h5,         1};
      tbl[7]  = '{1, 3'd1, 32'h0000_0005, 32'h6,         1};
      tbl[8]  = '{0, 3'd0, 32'h0000_0005, 32'h6,         0};
      tbl[9]  = '{1, 3'd3, 32'h7fff_ffff, 32'hffff_ffff, 1};
      tbl[10] = '{0, 3'd2, 32'hffff_ffff, 32'h0,         1};
      tbl[11] = '{0, 3'd7, 32'h0000_0005, 32'h5,         0};
      tbl[12] = '{1, 3'd6, 32'h0000_0005, 32'h5,         0};
      tbl[13] = '{0, 3'd1, 32'h1234_5678, 32'h1234_5678, 0};

      reset = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      rst(); rst();
      armed = 1'b1;

      // reset state, with a request held during reset
      cyc(1, 1, 0, 0, 0, 1, 0, 0, 0);
      chk("gnt0 in reset", s_g0, 0);
      chk("gnt1 in reset", s_g1, 0);
      idle(1);
      chk("reset busy", s_busy, 0);
      chk("reset res_valid", s_rv, 0);
      chk("reset res_id", s_rid, 0);
      chk("reset res_true", s_rt, 0);

      // single request
      cyc(0, 1, 3'd0, 32'h1234_5678, 32'h1234_5678, 0, 0, 0, 0);
      chk("single gnt0", s_g0, 1);
      idle(1);
      chk("single busy c1", s_busy, 1);
      chk("single gnt0 c1", s_g0, 0);
      idle(1);
      chk("single res_valid", s_rv, 1);
      chk("single res_id", s_rid, 0);
      chk("single res_true", s_rt, 1);
      chk("single busy c2", s_busy, 1);
      idle(1);
      chk("single done busy", s_busy, 0);
      chk("single done res_valid", s_rv, 0);
      chk("single hold res_true", s_rt, 1);

      // opcode table
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].id) cyc(0, 0, 0, 0, 0, 1, tbl[i].op, tbl[i].a, tbl[i].b);
         else           cyc(0, 1, tbl[i].op, tbl[i].a, tbl[i].b, 0, 0, 0, 0);
         chk($sformatf("vec%0d gnt", i), tbl[i].id ? s_g1 : s_g0, 1);
         idle(2);
         chk($sformatf("vec%0d res_valid", i), s_rv, 1);
         chk($sformatf("vec%0d res_id", i), s_rid, tbl[i].id);
         chk($sformatf("vec%0d res_true", i), s_rt, tbl[i].exp);
      end

      // contention after reset
      rst();
      for (int k = 0; k < 10; k++) begin
         bit eg, ew;
         cyc(0, 1, 3'd0, k, k, 1, 3'd1, k, k);
         eg = (k % 3 == 0);
`ifdef CMP_ARB_RR_EN
         ew = ((k / 3) % 2) == 1;
`else
         ew = 1'b0;
`endif
         chk($sformatf("contend c%0d gnt0", k), s_g0, eg && !ew);
         chk($sformatf("contend c%0d gnt1", k), s_g1, eg && ew);
      end
      idle(3);

      // request dropped during EVAL, re-raised in IDLE
      cyc(0, 1, 3'd0, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 3'd3, 32'h10, 0);
      chk("drop gnt1 in eval", s_g1, 0);
      idle(1);
      cyc(0, 0, 0, 0, 0, 1, 3'd3, 32'h10, 0);
      chk("reraise gnt1", s_g1, 1);
      idle(2);
      chk("reraise res_id", s_rid, 1);
      chk("reraise res_true", s_rt, 1);

      // reset mid-operation
      cyc(0, 1, 3'd1, 1, 2, 0, 0, 0, 0);
      chk("midrst gnt0", s_g0, 1);
      rst();
      idle(1);
      chk("midrst busy", s_busy, 0);
      chk("midrst res_valid c2", s_rv, 0);
      idle(1);
      chk("midrst res_valid c3", s_rv, 0);
      cyc(0, 1, 3'd0, 0, 0, 1, 3'd0, 0, 0);
      chk("midrst contest gnt0", s_g0, 1);
      chk("midrst contest gnt1", s_g1, 0);
      idle(2);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 60) == 0,
             $urandom_range(0, 1), 3'($urandom_range(0, 7)), pick(), pick(),
             $urandom_range(0, 1), 3'($urandom_range(0, 7)), pick(), pick());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; its ports SHALL be, one per line: name, direction, width, meaning, with clock and reset first.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 (D-stage branch unit) request.
- op0  input  3  requester 0 compare opcode.
- a0  input  32  requester 0 operand A.
- b0  input  32  requester 0 operand B.
- gnt0  output  1  grant to requester 0; operands captured this cycle.
- req1  input  1  requester 1 (M-stage conditional-trap unit) request.
- op1  input  3  requester 1 compare opcode.
- a1  input  32  requester 1 operand A.
- b1  input  32  requester 1 operand B.
- gnt1  output  1  grant to requester 1; operands captured this cycle.
- res_valid  output  1  one-cycle result strobe.
- res_id  output  1  requester that owns the result (0/1).
- res_true  output  1  compare outcome; meaningful only while res_valid=1.
- busy  output  1  high whenever state is not IDLE.

Function
REQ-002 The block SHALL share a single 32-bit comparator between two requesters via the FSM IDLE -> EVAL -> DONE -> IDLE.
REQ-003 In IDLE with any reqN=1, the block SHALL assert exactly one gntN combinationally in that cycle, capture opN/aN/bN and the id on the clock edge, and go to EVAL.
REQ-004 In IDLE with no request, the block SHALL stay in IDLE with gnt0=gnt1=0.
REQ-005 Grants SHALL occur only in IDLE; gnt0 and gnt1 SHALL never be high together, and SHALL be 0 in EVAL and DONE.
REQ-006 In EVAL, the block SHALL evaluate the captured operands, register res_true and res_id, and go to DONE.
REQ-007 In DONE, the block SHALL hold res_valid=1 for exactly one cycle, then return to IDLE.
REQ-008 Latency SHALL be grant cycle N -> res_valid in cycle N+2; peak throughput SHALL be one grant per 3 cycles.
REQ-009 A requester SHALL hold reqN and its operands stable until it sees gntN; the block SHALL sample operands only in the grant cycle.
REQ-010 A requester MAY drop reqN without a grant; the block SHALL treat that as no request, with no side effects.
REQ-011 Opcodes SHALL map as follows, with a and b as 32-bit two's complement: 000 EQ (a==b), 001 NE (a!=b), 010 LEZ (a<=0), 011 GTZ (a>0), 100 LTZ (a<0), 101 GEZ (a>=0); b SHALL be ignored for 010-101.
REQ-012 Opcodes 110 and 111 SHALL be granted normally and SHALL produce res_true=0.
REQ-013 The boundary 0x80000000 SHALL count as negative: LTZ=1 and GEZ=0.
REQ-014 The boundary 0x00000000 SHALL give LEZ=1, GEZ=1, GTZ=0 and LTZ=0.
REQ-015 The arbitration pointer last_id SHALL update only on a grant; in IDLE with req0=req1=1, arbitration SHALL follow REQ-021.
REQ-016 res_id and res_true SHALL hold their last values outside DONE.

Reset
REQ-017 On reset=1 at a rising edge, the block SHALL set state to IDLE and last_id to 1, so requester 0 wins the first simultaneous contest.
REQ-018 On reset, the block SHALL clear res_valid, res_id and res_true to 0; busy SHALL then read 0.
REQ-019 During reset, the block SHALL hold gnt0 and gnt1 at 0.
REQ-020 A reset during EVAL or DONE SHALL discard the operation in flight; no res_valid SHALL appear for it.

Configuration
REQ-021 Macro CMP_ARB_RR_EN SHALL select the arbitration policy on simultaneous requests:
- Defined: round-robin; grant the requester whose id != last_id.
- Undefined: fixed priority; requester 0 always wins; last_id is kept but unused.

Verification
REQ-022 The bench SHALL cover these directed scenarios, each as stimulus -> required response:
- Single request: req0=1, op0=000, a0=b0=0x12345678 in cycle 0 -> gnt0=1 in cycle 0; res_valid=1, res_id=0, res_true=1 in cycle 2; busy=1 in cycles 1-2.
- Sign boundary: req1=1, op1=100, a1=0x80000000 -> res_true=1; repeat with op1=101 -> res_true=0; a1=0 with op1=010 -> res_true=1.
- Contention with CMP_ARB_RR_EN defined: req0=req1=1 held after reset -> grant order 0,1,0,1 at cycles 0,3,6,9. Without the macro -> gnt0 at cycles 0,3,6; gnt1 never asserted.
- Request dropped: req1 pulsed for one cycle during EVAL -> no gnt1; req1 re-raised in IDLE -> granted in that same cycle.
- Reset mid-operation: grant req0 at cycle 0, reset=1 at cycle 1 -> no res_valid; busy=0 and gnts=0 from cycle 2; next contest goes to requester 0.
- Illegal opcode: op0=111, a0=b0=5 -> granted; res_valid at +2 with res_true=0.
